// File: rtl/rand_byte_ctrl_if.sv
// Output word handshake between the random byte controller and its consumer.
// The controller drives the word and its valid flag; the consumer drives ready.
interface rand_byte_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dataOut;
    logic             dataValid;
    logic             dataReady;

    modport master (
        output dataOut,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  dataOut,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/rand_byte_ctrl.sv
// Sequencer for the COSO TRNG serial-to-parallel shifter: warm-up discard,
// bit counting, word capture and valid/ready delivery with overrun flag.
module rand_byte_ctrl #(
    parameter int WIDTH       = 8,
    parameter int WARMUP_BITS = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             enable,
    input  logic             CSReq,
    input  logic [WIDTH-1:0] randByte,
    output logic             shiftEn,
    output logic             shiftClr,
    output logic             overrun,
    input  logic             clrOverrun,
    output logic             busy,
    rand_byte_ctrl_if.master out_if
);
    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        COLLECT
    } state_t;

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_BITS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HAS_WARM  = (WARMUP_BITS > 0);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             cap_pend;
    logic             cap_d;
    logic             clr_d;
    logic             load;
    logic             drop;

    // Strobes reach the shifter whenever running, warm-up included, so
    // stale bits from a previous run are flushed out.
    assign shiftEn = CSReq && (state != IDLE);
    assign busy    = (state != IDLE);

    // A capture is cancelled if enable falls in the capPend cycle.
    assign load = cap_pend && enable;
    assign drop = load && out_if.dataValid && !out_if.dataReady;

    // Next state, counter, capture request and shifter clear.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cap_d   = 1'b0;
        clr_d   = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                    state_d = HAS_WARM ? WARMUP : COLLECT;
                end
                WARMUP: begin
                    if (CSReq) begin
                        if (cnt == WARM_LAST) begin
                            state_d = COLLECT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + CNT_ONE;
                        end
                    end
                end
                COLLECT: begin
                    if (CSReq) begin
                        if (cnt == WORD_LAST) begin
                            cnt_d = '0;
                            cap_d = 1'b1;
                        end else begin
                            cnt_d = cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_pend <= 1'b0;
            shiftClr <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cap_pend <= cap_d;
            shiftClr <= clr_d;
        end
    end

    // Output word register, valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            out_if.dataOut   <= '0;
            out_if.dataValid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (load && !drop) begin
                out_if.dataOut   <= randByte;
                out_if.dataValid <= 1'b1;
            end else if (out_if.dataValid && out_if.dataReady) begin
                out_if.dataValid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clrOverrun) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rand_byte_ctrl.sv
// Self-checking bench for rand_byte_ctrl: directed table, corner sequences
// and randomized traffic against a strobe-count reference model.
module tb_rand_byte_ctrl;
    localparam int WIDTH = 8;
    localparam int WARM  = 16;

    logic             clk = 1'b0;
    logic             rstN;
    logic             enable;
    logic             CSReq;
    logic [WIDTH-1:0] randByte;
    logic             shiftEn;
    logic             shiftClr;
    logic             overrun;
    logic             clrOverrun;
    logic             busy;

    rand_byte_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rand_byte_ctrl #(
        .WIDTH(WIDTH),
        .WARMUP_BITS(WARM),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .enable(enable),
        .CSReq(CSReq),
        .randByte(randByte),
        .shiftEn(shiftEn),
        .shiftClr(shiftClr),
        .overrun(overrun),
        .clrOverrun(clrOverrun),
        .busy(busy),
        .out_if(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: running flag, strobes counted since start,
    // pending load, output word and a behavioural shifter.
    bit         m_active;
    bit         m_clr;
    bit         m_pend;
    bit         m_valid;
    bit         m_ovr;
    logic [7:0] m_out;
    logic [7:0] m_sreg = '0;
    int         m_strobes;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_active  = 0;
        m_clr     = 0;
        m_pend    = 0;
        m_valid   = 0;
        m_ovr     = 0;
        m_out     = '0;
        m_strobes = 0;
    endfunction

    function automatic void model_edge(logic en, logic cs, logic b, logic rdy, logic clr);
        bit load;
        bit drop;
        bit pend_n;
        load = m_pend && en;
        drop = load && m_valid && !rdy;
        if (load && !drop) begin
            m_out   = m_sreg;
            m_valid = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (m_clr) m_sreg = '0;
        else if (cs && m_active) m_sreg = {m_sreg[6:0], b};
        pend_n = 0;
        if (!en) begin
            m_active  = 0;
            m_strobes = 0;
            m_clr     = 0;
        end else if (!m_active) begin
            m_active  = 1;
            m_strobes = 0;
            m_clr     = 1;
        end else begin
            m_clr = 0;
            if (cs) begin
                m_strobes++;
                if (m_strobes > WARM && (m_strobes - WARM) % WIDTH == 0)
                    pend_n = 1;
            end
        end
        m_pend = pend_n;
    endfunction

    // One clock: drive inputs, check shiftEn, clock, check registered outputs.
    task automatic step(input logic en, input logic cs, input logic b,
                        input logic rdy, input logic clr);
        if (m_clr) cs = 1'b0;
        enable        = en;
        CSReq         = cs;
        bus.dataReady = rdy;
        clrOverrun    = clr;
        #1;
        chk("shiftEn", {31'b0, shiftEn}, {31'b0, cs && m_active});
        @(posedge clk);
        model_edge(en, cs, b, rdy, clr);
        @(negedge clk);
        randByte = m_sreg;
        chk("dataOut", {24'b0, bus.dataOut}, {24'b0, m_out});
        chk("dataValid", {31'b0, bus.dataValid}, {31'b0, m_valid});
        chk("overrun", {31'b0, overrun}, {31'b0, m_ovr});
        chk("shiftClr", {31'b0, shiftClr}, {31'b0, m_clr});
        chk("busy", {31'b0, busy}, {31'b0, m_active});
    endtask

    typedef struct {
        logic       en;
        logic       cs;
        logic       b;
        logic       rdy;
        logic       exp_clr;
        logic       exp_valid;
        logic       exp_busy;
        logic [7:0] exp_out;
    } vec_t;

    function automatic vec_t mk(logic en, logic cs, logic b, logic rdy,
                                logic ec, logic ev, logic eb, logic [7:0] eo);
        vec_t v;
        v.en = en; v.cs = cs; v.b = b; v.rdy = rdy;
        v.exp_clr = ec; v.exp_valid = ev; v.exp_busy = eb; v.exp_out = eo;
        return v;
    endfunction

    vec_t tbl[28];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int ld;
        bit cleared;
        bit hit;

        pat = 8'hB2;
        tbl[0] = mk(1, 0, 0, 0, 1, 0, 1, 8'h00);
        tbl[1] = mk(1, 0, 0, 0, 0, 0, 1, 8'h00);
        for (int s = 1; s <= 24; s++) begin
            logic bb;
            bb = (s >= 17) ? pat[24 - s] : logic'(s % 2);
            tbl[s + 1] = mk(1, 1, bb, 0, 0, 0, 1, 8'h00);
        end
        tbl[26] = mk(1, 0, 0, 0, 0, 1, 1, 8'hB2);
        tbl[27] = mk(1, 0, 0, 0, 0, 1, 1, 8'hB2);

        rstN = 0; enable = 0; CSReq = 0; randByte = '0;
        bus.dataReady = 0; clrOverrun = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_dataOut", {24'b0, bus.dataOut}, 32'h0);
        chk("rst_dataValid", {31'b0, bus.dataValid}, 32'h0);
        chk("rst_overrun", {31'b0, overrun}, 32'h0);
        chk("rst_shiftClr", {31'b0, shiftClr}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        rstN = 1;
        step(0, 1, 1, 0, 0);

        // Start, warm-up, first word 0xB2 two edges after strobe 24.
        for (int i = 0; i < 28; i++) begin
            step(tbl[i].en, tbl[i].cs, tbl[i].b, tbl[i].rdy, 1'b0);
            chk($sformatf("tbl%0d_clr", i), {31'b0, shiftClr}, {31'b0, tbl[i].exp_clr});
            chk($sformatf("tbl%0d_valid", i), {31'b0, bus.dataValid}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].exp_busy});
            chk($sformatf("tbl%0d_out", i), {24'b0, bus.dataOut}, {24'b0, tbl[i].exp_out});
        end

        // Continuous strobes with an always-ready consumer.
        for (int i = 0; i < 40; i++) step(1, 1, 1'($urandom), 1, 0);
        chk("stream_no_overrun", {31'b0, overrun}, 32'h0);

        // Stalled consumer: drops, clear, then clear on a drop edge.
        ld = 0;
        cleared = 0;
        for (int i = 0; i < 40 && ld < 3; i++) begin
            bit p;
            logic c;
            p = m_pend;
            c = 0;
            if (ld == 2 && !p && !cleared) begin c = 1; cleared = 1; end
            if (ld == 2 && p && cleared) c = 1;
            step(1, 1, 1'($urandom), 0, c);
            if (p) ld++;
            if (p && ld == 2) chk("ovr_second_drop", {31'b0, overrun}, 32'h1);
            if (c && !p) chk("ovr_cleared", {31'b0, overrun}, 32'h0);
            if (p && ld == 3) chk("ovr_set_wins", {31'b0, overrun}, 32'h1);
        end
        chk("three_loads", ld, 3);

        // Accept on the exact load edge of the next word.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            bit p;
            logic [7:0] nw;
            p = m_pend;
            nw = m_sreg;
            step(1, 1, 1'($urandom), p, 0);
            if (p) begin
                hit = 1;
                chk("accload_valid", {31'b0, bus.dataValid}, 32'h1);
                chk("accload_out", {24'b0, bus.dataOut}, {24'b0, nw});
                chk("accload_ovr", {31'b0, overrun}, 32'h0);
            end
        end
        chk("accload_seen", {31'b0, hit}, 32'h1);

        // Enable drops after 5 collect strobes, then full restart.
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1, 1, 1'($urandom), 1, 0);
            if (m_strobes > WARM && (m_strobes - WARM) % WIDTH == 5) hit = 1;
        end
        chk("five_strobes_seen", {31'b0, hit}, 32'h1);
        step(0, 1, 1, 1, 0);
        chk("stop_busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("restart_clr", {31'b0, shiftClr}, 32'h1);
        for (int i = 0; i < 30; i++) step(1, 1, 1'($urandom), 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            step(logic'($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
                 1'($urandom), logic'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-word while a word is held.
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(1, 1, 1'($urandom), 0, 0);
            if (m_valid && m_strobes > WARM && (m_strobes - WARM) % WIDTH == 3) hit = 1;
        end
        chk("midword_reached", {31'b0, hit}, 32'h1);
        CSReq = 1;
        #2;
        rstN = 0;
        #1;
        model_reset();
        chk("arst_dataOut", {24'b0, bus.dataOut}, 32'h0);
        chk("arst_dataValid", {31'b0, bus.dataValid}, 32'h0);
        chk("arst_overrun", {31'b0, overrun}, 32'h0);
        chk("arst_shiftClr", {31'b0, shiftClr}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_shiftEn", {31'b0, shiftEn}, 32'h0);
        @(negedge clk);
        rstN = 1;
        for (int i = 0; i < 30; i++) step(1, 1, 1'($urandom), 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rand_byte_ctrl.md
Name: rand_byte_ctrl

Overview:
- Sequencing controller for the 8-bit serial-to-parallel random-bit shift register in the COSO TRNG datapath.
- Gates the coherent sampler's bit strobe into the shifter and discards a configurable warm-up run of bits after each start.
- Counts shifted bits, captures each completed byte into an output register and presents it on a valid/ready handshake to the downstream consumer (FIFO/UART).
- Flags overruns when the consumer stalls.

Parameters:
- WIDTH, 8: bits per output word; must match the shifter width.
- WARMUP_BITS, 16: strobes discarded after each start; 0 means go straight to collecting.
- CNT_W, 8: width of the internal bit/warm-up counter; must satisfy 2^CNT_W > max(WIDTH, WARMUP_BITS).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rstN  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run, 0 = stop.
- CSReq  in  1  one-cycle strobe from the coherent sampler: random bit is stable.
- randByte  in  WIDTH  current shifter contents.
- shiftEn  out  WIDTH-independent 1  strobe to the shifter's CSReq input.
- shiftClr  out  1  synchronous clear to the shifter's rst input.
- dataOut  out  WIDTH  captured random word.
- dataValid  out  1  dataOut holds an unconsumed word.
- dataReady  in  1  consumer accepts when dataValid && dataReady at a rising edge.
- overrun  out  1  sticky flag: a completed word was dropped.
- clrOverrun  in  1  synchronous clear for overrun.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rstN=0, asynchronous) sets:
  - state = IDLE; counter = 0; capPend = 0.
  - dataOut = 0, dataValid = 0, overrun = 0, shiftClr = 0.
- States:
  - IDLE: counter held at 0. enable=1 moves to WARMUP if WARMUP_BITS>0, else to COLLECT. shiftClr is registered high for exactly the one cycle after this transition.
  - WARMUP: each strobe increments the counter. The strobe with counter==WARMUP_BITS-1 moves to COLLECT and sets the counter to 0.
  - COLLECT: each strobe increments the counter. The strobe with counter==WIDTH-1 sets the counter to 0 and sets capPend=1 for one cycle.
  - Any state with enable=0: next edge goes to IDLE, clears the counter and cancels capPend. dataValid, dataOut and overrun are unaffected.
- shiftEn = CSReq && state!=IDLE, combinational. This keeps the strobe aligned with randBit at the shifter; warm-up strobes are passed so stale bits are flushed.
- shiftClr has priority in the shifter. A CSReq in the shiftClr cycle is still counted (documented: the first word then has one fewer fresh bit). The bench must not strobe in that cycle.
- Capture timing:
  - The final strobe is sampled at edge E0; capPend is high during the following cycle.
  - At E1, randByte is loaded into dataOut and dataValid rises, i.e. 2 edges after the final strobe's cycle.
  - A strobe in the capPend cycle is allowed (back-to-back strobes). It begins the next word; the E1 load takes the pre-E1 randByte.
- Handshake:
  - dataValid clears on an edge where dataValid && dataReady, unless a load occurs on the same edge; then dataValid stays 1 with the new word.
  - dataOut is stable while dataValid=1 and not accepted.
- Overrun: at a load edge with dataValid=1 && dataReady=0:
  - The new word is dropped and dataOut is unchanged.
  - overrun is set.
  - The counter continues normally.
- clrOverrun clears overrun at the next edge. If a set and a clear occur on the same edge, set wins.
- Strobes in IDLE are ignored and not forwarded.
- Counters never exceed their terminal value; no wrap occurs other than the defined reset to 0.
- rstN asserted mid-word: immediate return to reset values; the partial word is lost.

Test Plan:
- Reset, then enable=1 with WARMUP_BITS=16, WIDTH=8, 24 strobes with bits 16..23 = 1,0,1,1,0,0,1,0 -> shiftClr pulses once after start; dataOut=8'hB2 and dataValid=1 exactly 2 edges after strobe 24.
- CSReq every cycle, dataReady tied 1 -> one word every 8 cycles, no overrun, shiftEn==CSReq throughout COLLECT.
- dataReady=0 across two completed words -> first word held, overrun=1 at the second load; clrOverrun=1 on the same edge as a third drop -> overrun stays 1.
- Accept (dataReady=1) on the exact load edge of the next word -> dataValid stays 1, dataOut updates, overrun=0.
- enable drops after 5 COLLECT strobes and is raised again -> IDLE, counter 0, capPend cancelled, new shiftClr pulse and full warm-up repeated; strobes while in IDLE give shiftEn=0.
- rstN pulsed low asynchronously mid-word with dataValid=1 -> all outputs 0 immediately, busy=0.
